// File: rtl/z80_bus_pkg.sv
// Shared Z80 bus definitions: cycle classes, front-end FSM states and the
// strobe classifier. The downstream address decoder imports this package too.
package z80_bus_pkg;

  typedef enum logic [2:0] {
    CYC_NONE    = 3'd0,
    CYC_FETCH   = 3'd1,
    CYC_MEM_RD  = 3'd2,
    CYC_MEM_WR  = 3'd3,
    CYC_IO_RD   = 3'd4,
    CYC_IO_WR   = 3'd5,
    CYC_INTACK  = 3'd6,
    CYC_ILLEGAL = 3'd7
  } cyc_type_e;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_QUAL      = 2'd2,
    ST_ACTIVE    = 2'd3
  } bus_state_e;

  // Bit positions inside the packed strobe vector (all strobes active-low)
  localparam int STB_RD   = 0;
  localparam int STB_WR   = 1;
  localparam int STB_M1   = 2;
  localparam int STB_IORQ = 3;
  localparam int STB_MREQ = 4;
  localparam int STB_W    = 5;

  function automatic cyc_type_e classify(input logic [STB_W-1:0] stb);
    logic mreq, iorq, m1, rd, wr;
    mreq = ~stb[STB_MREQ];
    iorq = ~stb[STB_IORQ];
    m1   = ~stb[STB_M1];
    rd   = ~stb[STB_RD];
    wr   = ~stb[STB_WR];
    if (mreq && iorq)      return CYC_ILLEGAL;
    else if (mreq && rd && m1) return CYC_FETCH;
    else if (mreq && rd)   return CYC_MEM_RD;
    else if (mreq && wr)   return CYC_MEM_WR;
    else if (iorq && m1)   return CYC_INTACK;
    else if (iorq && rd)   return CYC_IO_RD;
    else if (iorq && wr)   return CYC_IO_WR;
    else                   return CYC_NONE;
  endfunction

endpackage

// File: rtl/z80_sync_ff.sv
// Multi-stage flip-flop synchroniser for asynchronous Z80 pins, with a
// configurable reset value so strobes come out of reset deasserted.
module z80_sync_ff #(
  parameter int   WIDTH     = 1,
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= {WIDTH{RESET_VAL}};
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/z80_bus_sync.sv
// Z80 bus front end: synchronises the pins, filters strobe glitches and emits
// one start/end pulse pair per qualified machine cycle with captured addr/data.
module z80_bus_sync
  import z80_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] z80_a,
  input  logic [7:0]  z80_d_in,
  input  logic        z80_rd,
  input  logic        z80_wr,
  input  logic        z80_m1,
  input  logic        z80_iorq,
  input  logic        z80_mreq,
  output logic        cyc_start,
  output logic        cyc_end,
  output logic [2:0]  cyc_type,
  output logic [15:0] cyc_addr,
  output logic [7:0]  cyc_wdata,
  output logic        bus_active,
  output logic [7:0]  glitch_cnt
);

  localparam logic [7:0] FILT_MAX  = 8'(FILT_CYCLES);
  localparam logic [7:0] FLUSH_MAX = 8'(SYNC_STAGES);

  logic [STB_W-1:0] stb_raw, stb;
  logic [15:0]      addr_s;
  logic [7:0]       data_s;

  assign stb_raw = {z80_mreq, z80_iorq, z80_m1, z80_wr, z80_rd};

  z80_sync_ff #(.WIDTH(STB_W), .STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_stb (
    .clk(clk), .rst_n(rst_n), .d(stb_raw), .q(stb)
  );

  z80_sync_ff #(.WIDTH(16), .STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_addr (
    .clk(clk), .rst_n(rst_n), .d(z80_a), .q(addr_s)
  );

  z80_sync_ff #(.WIDTH(8), .STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_data (
    .clk(clk), .rst_n(rst_n), .d(z80_d_in), .q(data_s)
  );

  bus_state_e state;
  cyc_type_e  cur_type, qual_type, last_type;
  logic [7:0] filt_cnt, flush_cnt;
  logic       qualifiable, do_start;

  assign cur_type    = classify(stb);
  assign qualifiable = (cur_type != CYC_NONE) && (cur_type != CYC_ILLEGAL);

  always_comb begin
    do_start = 1'b0;
    if (state == ST_IDLE && qualifiable && FILT_MAX <= 8'd1)
      do_start = 1'b1;
    else if (state == ST_QUAL && cur_type == qual_type && (filt_cnt + 8'd1) >= FILT_MAX)
      do_start = 1'b1;
  end

  // After reset the synchronisers hold idle values, so WAIT_IDLE ignores them
  // until they have refilled from the pins; otherwise a cycle still in progress
  // across reset would appear to start fresh.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_WAIT_IDLE;
      flush_cnt  <= 8'd0;
      filt_cnt   <= 8'd0;
      qual_type  <= CYC_NONE;
      last_type  <= CYC_NONE;
      cyc_start  <= 1'b0;
      cyc_end    <= 1'b0;
      cyc_type   <= CYC_NONE;
      cyc_addr   <= 16'd0;
      cyc_wdata  <= 8'd0;
      bus_active <= 1'b0;
      glitch_cnt <= 8'd0;
    end else begin
      cyc_start <= 1'b0;
      cyc_end   <= 1'b0;
      last_type <= cur_type;
      if (do_start) begin
        cyc_start  <= 1'b1;
        bus_active <= 1'b1;
        cyc_type   <= cur_type;
        cyc_addr   <= addr_s;
        cyc_wdata  <= (cur_type == CYC_MEM_WR || cur_type == CYC_IO_WR) ? data_s : 8'd0;
        state      <= ST_ACTIVE;
      end else begin
        case (state)
          ST_WAIT_IDLE: begin
            if (flush_cnt < FLUSH_MAX) flush_cnt <= flush_cnt + 8'd1;
            else if (cur_type == CYC_NONE) state <= ST_IDLE;
          end
          ST_IDLE: begin
            bus_active <= 1'b0;
            // A held ILLEGAL combination is one glitch, not one per clock
            if (cur_type == CYC_ILLEGAL) begin
              if (last_type != CYC_ILLEGAL && glitch_cnt != 8'hFF)
                glitch_cnt <= glitch_cnt + 8'd1;
            end else if (cur_type != CYC_NONE) begin
              qual_type <= cur_type;
              filt_cnt  <= 8'd1;
              state     <= ST_QUAL;
            end
          end
          ST_QUAL: begin
            if (cur_type == qual_type) begin
              filt_cnt <= filt_cnt + 8'd1;
            end else begin
              if (glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
              state <= ST_IDLE;
            end
          end
          ST_ACTIVE: begin
            if (cur_type != cyc_type) begin
              cyc_end <= 1'b1;
              state   <= ST_IDLE;
            end
          end
          default: state <= ST_WAIT_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_z80_bus_sync.sv
// Directed bench for z80_bus_sync: hand-computed expectations checked with
// immediate assertions, plus a negedge monitor recording every start/end pulse.
module tb_z80_bus_sync;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] z80_a = 16'd0;
  logic [7:0]  z80_d_in = 8'd0;
  logic        z80_rd = 1'b1, z80_wr = 1'b1, z80_m1 = 1'b1, z80_iorq = 1'b1, z80_mreq = 1'b1;
  logic        cyc_start, cyc_end, bus_active;
  logic [2:0]  cyc_type;
  logic [15:0] cyc_addr;
  logic [7:0]  cyc_wdata, glitch_cnt;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int end_cnt = 0;
  int idle_run = 0;
  int type_q[$], addr_q[$], wdata_q[$], gap_q[$];
  int s0, e0;

  z80_bus_sync #(.SYNC_STAGES(2), .FILT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .z80_a(z80_a), .z80_d_in(z80_d_in),
    .z80_rd(z80_rd), .z80_wr(z80_wr), .z80_m1(z80_m1), .z80_iorq(z80_iorq),
    .z80_mreq(z80_mreq), .cyc_start(cyc_start), .cyc_end(cyc_end),
    .cyc_type(cyc_type), .cyc_addr(cyc_addr), .cyc_wdata(cyc_wdata),
    .bus_active(bus_active), .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Strobe arguments are pin levels (active-low)
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d,
                               input logic mreq, input logic iorq, input logic m1,
                               input logic rd, input logic wr);
    z80_a    = a;
    z80_d_in = d;
    z80_mreq = mreq;
    z80_iorq = iorq;
    z80_m1   = m1;
    z80_rd   = rd;
    z80_wr   = wr;
  endtask

  task automatic busIdle();
    applyStimulus(z80_a, z80_d_in, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (cyc_start || cyc_end)
      checkOutput("start_end_exclusive", {31'd0, cyc_start & cyc_end}, 32'd0);
    if (cyc_start) begin
      start_cnt++;
      type_q.push_back(int'(cyc_type));
      addr_q.push_back(int'(cyc_addr));
      wdata_q.push_back(int'(cyc_wdata));
      gap_q.push_back(idle_run);
    end
    if (cyc_end) begin
      end_cnt++;
      idle_run = 0;
    end else if (!bus_active) begin
      idle_run++;
    end
  end

  initial begin
    $display("[TB] start");
    busIdle();
    rst_n = 1'b0;
    tick(3);
    checkOutput("rst_start", cyc_start, 0);
    checkOutput("rst_end", cyc_end, 0);
    checkOutput("rst_type", cyc_type, 0);
    checkOutput("rst_addr", cyc_addr, 0);
    checkOutput("rst_wdata", cyc_wdata, 0);
    checkOutput("rst_active", bus_active, 0);
    checkOutput("rst_glitch", glitch_cnt, 0);
    rst_n = 1'b1;
    tick(6);

    // IO write: start must appear after the 4th edge, not the 3rd
    s0 = start_cnt; e0 = end_cnt;
    applyStimulus(16'd12345, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(3);
    checkOutput("iowr_no_start_edge3", cyc_start, 0);
    tick(1);
    checkOutput("iowr_start_edge4", cyc_start, 1);
    checkOutput("iowr_type", cyc_type, 5);
    checkOutput("iowr_addr", cyc_addr, 16'd12345);
    checkOutput("iowr_wdata", cyc_wdata, 8'h55);
    checkOutput("iowr_active", bus_active, 1);
    tick(6);
    busIdle();
    tick(6);
    checkOutput("iowr_starts", start_cnt - s0, 1);
    checkOutput("iowr_ends", end_cnt - e0, 1);
    checkOutput("iowr_glitch", glitch_cnt, 0);
    checkOutput("iowr_inactive", bus_active, 0);

    // Opcode fetch followed by refresh (mreq stays low)
    s0 = start_cnt; e0 = end_cnt;
    applyStimulus(16'h0000, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(6);
    applyStimulus(16'h0000, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(4);
    busIdle();
    tick(6);
    checkOutput("fetch_starts", start_cnt - s0, 1);
    checkOutput("fetch_ends", end_cnt - e0, 1);
    checkOutput("fetch_type", cyc_type, 1);
    checkOutput("fetch_addr", cyc_addr, 16'h0000);
    checkOutput("fetch_wdata", cyc_wdata, 0);

    // One-clock IO_RD glitches, saturating at 255
    s0 = start_cnt;
    applyStimulus(16'h0100, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(1);
    busIdle();
    tick(3);
    checkOutput("glitch_one", glitch_cnt, 1);
    for (int i = 0; i < 253; i++) begin
      applyStimulus(16'h0100, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      tick(1);
      busIdle();
      tick(3);
    end
    checkOutput("glitch_254", glitch_cnt, 254);
    for (int i = 0; i < 46; i++) begin
      applyStimulus(16'h0100, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      tick(1);
      busIdle();
      tick(3);
    end
    checkOutput("glitch_saturated", glitch_cnt, 255);
    checkOutput("glitch_no_start", start_cnt - s0, 0);

    // Reset, then an illegal mreq+iorq combination held for 8 clocks
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    checkOutput("rst_clears_glitch", glitch_cnt, 0);
    s0 = start_cnt;
    applyStimulus(16'h0200, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(8);
    busIdle();
    tick(6);
    checkOutput("illegal_glitch", glitch_cnt, 1);
    checkOutput("illegal_no_start", start_cnt - s0, 0);

    // Reset in the middle of an active MEM_RD
    applyStimulus(16'h1234, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(6);
    checkOutput("memrd_active", bus_active, 1);
    checkOutput("memrd_type", cyc_type, 2);
    s0 = start_cnt; e0 = end_cnt;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    busIdle();
    tick(6);
    checkOutput("midrst_no_start", start_cnt - s0, 0);
    checkOutput("midrst_no_end", end_cnt - e0, 0);
    checkOutput("midrst_inactive", bus_active, 0);
    checkOutput("midrst_type", cyc_type, 0);

    s0 = start_cnt; e0 = end_cnt;
    applyStimulus(16'd12347, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(8);
    busIdle();
    tick(6);
    checkOutput("iord_starts", start_cnt - s0, 1);
    checkOutput("iord_ends", end_cnt - e0, 1);
    checkOutput("iord_type", cyc_type, 4);
    checkOutput("iord_addr", cyc_addr, 16'd12347);
    checkOutput("iord_wdata", cyc_wdata, 0);

    // Back-to-back MEM_WR then IO_RD with a single NONE clock between
    s0 = start_cnt; e0 = end_cnt;
    applyStimulus(16'h4000, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(6);
    busIdle();
    tick(1);
    applyStimulus(16'd12345, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(6);
    busIdle();
    tick(6);
    checkOutput("b2b_starts", start_cnt - s0, 2);
    checkOutput("b2b_ends", end_cnt - e0, 2);
    checkOutput("b2b_glitch", glitch_cnt, 0);
    if (type_q.size() >= s0 + 2) begin
      checkOutput("b2b_type0", type_q[s0], 3);
      checkOutput("b2b_addr0", addr_q[s0], 32'h4000);
      checkOutput("b2b_wdata0", wdata_q[s0], 32'hAA);
      checkOutput("b2b_type1", type_q[s0+1], 4);
      checkOutput("b2b_addr1", addr_q[s0+1], 32'd12345);
      checkOutput("b2b_wdata1", wdata_q[s0+1], 0);
      checkOutput("b2b_gap", {31'd0, gap_q[s0+1] >= 1}, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
